// File: rtl/div_param_if.sv
// Request/result bundle for div_param: operands and control from the
// requester (master), status and {remainder, quotient} back from the divider (slave).
interface div_param_if #(
  parameter int WIDTH = 32
);
  logic                 start_i;
  logic                 annul_i;
  logic                 signed_div_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic                 busy_o;
  logic                 ready_o;
  logic [2*WIDTH-1:0]   result_o;
  logic                 div_zero_o;
  logic                 overflow_o;

  modport master (
    output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    input  busy_o, ready_o, result_o, div_zero_o, overflow_o
  );

  modport slave (
    input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    output busy_o, ready_o, result_o, div_zero_o, overflow_o
  );
endinterface

// File: rtl/div_param.sv
// Iterative restoring divider, BPC quotient bits per clock, signed/unsigned,
// truncating semantics. Zero divisor and signed MIN/-1 bypass the iteration.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start_i; operands captured on accept
// CALC  | BPC subtract-shift steps per edge, WIDTH/BPC edges
// FIX   | apply result signs, register result_o
// DONE  | ready_o pulse, back to IDLE on the next edge
module div_param #(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic      clk,
  input  logic      resetn,
  div_param_if.slave bus
);

  localparam int ITER = WIDTH / BPC;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CW-1:0]    CNT_LAST = CW'(ITER - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_dvs;
  logic               r_signed;
  logic               r_neg_dvd;
  logic               r_neg_dvs;
  logic [2*WIDTH-1:0] r_result;
  logic               r_div_zero;
  logic               r_overflow;

  logic               w_accept;
  logic               w_op1_neg;
  logic               w_op2_neg;
  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic               w_zero;
  logic               w_ovf;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH-1:0]   w_step_rem;
  logic [WIDTH-1:0]   w_step_quo;
  logic [WIDTH-1:0]   w_fix_rem;
  logic [WIDTH-1:0]   w_fix_quo;

  assign w_accept  = (r_state == S_IDLE) && bus.start_i && !bus.annul_i;
  assign w_op1_neg = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
  assign w_op2_neg = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
  assign w_mag1    = w_op1_neg ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
  assign w_mag2    = w_op2_neg ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;
  assign w_zero    = (bus.opdata2_i == '0);
  assign w_ovf     = bus.signed_div_i && (bus.opdata1_i == MIN_VAL) &&
                     (bus.opdata2_i == {WIDTH{1'b1}});

  // The dividend magnitude lives in r_quo and shifts out MSB-first into the
  // partial remainder while quotient bits shift in at the bottom.
  always_comb begin
    w_shift    = '0;
    w_step_rem = r_rem;
    w_step_quo = r_quo;
    for (int i = 0; i < BPC; i++) begin
      w_shift    = {w_step_rem, w_step_quo[WIDTH-1]};
      w_step_quo = {w_step_quo[WIDTH-2:0], 1'b0};
      if (w_shift >= {1'b0, r_dvs}) begin
        w_shift       = w_shift - {1'b0, r_dvs};
        w_step_quo[0] = 1'b1;
      end
      w_step_rem = w_shift[WIDTH-1:0];
    end
  end

  assign w_fix_quo = (r_signed && (r_neg_dvd ^ r_neg_dvs)) ? (~r_quo + 1'b1) : r_quo;
  assign w_fix_rem = (r_signed && r_neg_dvd) ? (~r_rem + 1'b1) : r_rem;

  // Sequencer and datapath registers; result and flags only move on accept or FIX.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dvs      <= '0;
      r_signed   <= 1'b0;
      r_neg_dvd  <= 1'b0;
      r_neg_dvs  <= 1'b0;
      r_result   <= '0;
      r_div_zero <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_signed   <= bus.signed_div_i;
            r_neg_dvd  <= w_op1_neg;
            r_neg_dvs  <= w_op2_neg;
            r_cnt      <= '0;
            r_div_zero <= 1'b0;
            r_overflow <= 1'b0;
            if (w_zero) begin
              r_result   <= {bus.opdata1_i, {WIDTH{1'b1}}};
              r_div_zero <= 1'b1;
              r_state    <= S_DONE;
            end else if (w_ovf) begin
              r_result   <= {{WIDTH{1'b0}}, MIN_VAL};
              r_overflow <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_rem   <= '0;
              r_quo   <= w_mag1;
              r_dvs   <= w_mag2;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (bus.annul_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_rem <= w_step_rem;
            r_quo <= w_step_quo;
            if (r_cnt == CNT_LAST) begin
              r_cnt   <= '0;
              r_state <= S_FIX;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_FIX: begin
          if (bus.annul_i) begin
            r_state <= S_IDLE;
          end else begin
            r_result <= {w_fix_rem, w_fix_quo};
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o     = (r_state != S_IDLE);
  assign bus.ready_o    = (r_state == S_DONE);
  assign bus.result_o   = r_result;
  assign bus.div_zero_o = r_div_zero;
  assign bus.overflow_o = r_overflow;

endmodule

// File: tb/tb_div_param.sv
// Runs BPC=1, 2 and 4 dividers side by side on identical stimulus and checks
// them against an arithmetic reference model.
module tb_div_param;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          annul = 1'b0;
  logic          sdiv = 1'b0;
  logic [W-1:0]  op1 = '0;
  logic [W-1:0]  op2 = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_param_if #(.WIDTH(W)) if_b1 ();
  div_param_if #(.WIDTH(W)) if_b2 ();
  div_param_if #(.WIDTH(W)) if_b4 ();

  assign if_b1.start_i = start;  assign if_b1.annul_i = annul;  assign if_b1.signed_div_i = sdiv;
  assign if_b1.opdata1_i = op1;  assign if_b1.opdata2_i = op2;
  assign if_b2.start_i = start;  assign if_b2.annul_i = annul;  assign if_b2.signed_div_i = sdiv;
  assign if_b2.opdata1_i = op1;  assign if_b2.opdata2_i = op2;
  assign if_b4.start_i = start;  assign if_b4.annul_i = annul;  assign if_b4.signed_div_i = sdiv;
  assign if_b4.opdata1_i = op1;  assign if_b4.opdata2_i = op2;

  div_param #(.WIDTH(W), .BPC(1)) u_b1 (.clk(clk), .resetn(resetn), .bus(if_b1));
  div_param #(.WIDTH(W), .BPC(2)) u_b2 (.clk(clk), .resetn(resetn), .bus(if_b2));
  div_param #(.WIDTH(W), .BPC(4)) u_b4 (.clk(clk), .resetn(resetn), .bus(if_b4));

  logic          rdy [3];
  logic          bsy [3];
  logic          dz  [3];
  logic          ov  [3];
  logic [2*W-1:0] res [3];

  assign rdy[0] = if_b1.ready_o;  assign bsy[0] = if_b1.busy_o;  assign res[0] = if_b1.result_o;
  assign dz[0]  = if_b1.div_zero_o; assign ov[0] = if_b1.overflow_o;
  assign rdy[1] = if_b2.ready_o;  assign bsy[1] = if_b2.busy_o;  assign res[1] = if_b2.result_o;
  assign dz[1]  = if_b2.div_zero_o; assign ov[1] = if_b2.overflow_o;
  assign rdy[2] = if_b4.ready_o;  assign bsy[2] = if_b4.busy_o;  assign res[2] = if_b4.result_o;
  assign dz[2]  = if_b4.div_zero_o; assign ov[2] = if_b4.overflow_o;

  int             obs_lat    [3];
  int             obs_pulses [3];
  logic [2*W-1:0] obs_res    [3];
  logic           obs_dz     [3];
  logic           obs_ov     [3];
  logic [2*W-1:0] obs_end_res[3];
  logic           obs_end_dz [3];
  logic           obs_end_ov [3];

  function automatic int bpc_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
  endfunction

  // Truncating division from plain arithmetic, plus the two special cases.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sg, output logic e_dz, output logic e_ov);
    longint sa, sb, q, r;
    logic [W-1:0] uq, ur;
    e_dz = 1'b0;
    e_ov = 1'b0;
    if (b == 0) begin
      e_dz = 1'b1;
      return {a, 32'hFFFF_FFFF};
    end
    if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e_ov = 1'b1;
      return {32'h0, 32'h8000_0000};
    end
    if (sg) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                        input bit aligned);
    if (!aligned) @(negedge clk);
    op1 = a; op2 = b; sdiv = sg; annul = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op1 = $urandom; op2 = $urandom; sdiv = 1'($urandom_range(0, 1));
  endtask

  // Sample k = value present at the k-th edge after the accepting edge.
  task automatic observe(input int cycles);
    for (int i = 0; i < 3; i++) begin
      obs_lat[i] = -1; obs_pulses[i] = 0; obs_res[i] = '0; obs_dz[i] = 1'b0; obs_ov[i] = 1'b0;
    end
    for (int k = 1; k <= cycles; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rdy[i]) begin
          obs_pulses[i]++;
          if (obs_lat[i] < 0) begin
            obs_lat[i] = k; obs_res[i] = res[i]; obs_dz[i] = dz[i]; obs_ov[i] = ov[i];
          end
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      obs_end_res[i] = res[i]; obs_end_dz[i] = dz[i]; obs_end_ov[i] = ov[i];
    end
  endtask

  task automatic test_single_divide(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic sg, input string name, input bit aligned);
    logic [2*W-1:0] e_res;
    logic e_dz, e_ov;
    int e_lat;
    e_res = model(a, b, sg, e_dz, e_ov);
    launch(a, b, sg, aligned);
    observe(40);
    for (int i = 0; i < 3; i++) begin
      e_lat = (e_dz || e_ov) ? 1 : (W / bpc_of(i) + 2);
      checks++;
      if (obs_lat[i] !== e_lat) begin
        errors++;
        $display("FAIL %s[bpc%0d] latency: got %0d want %0d", name, bpc_of(i), obs_lat[i], e_lat);
      end
      checks++;
      if (obs_res[i] !== e_res) begin
        errors++;
        $display("FAIL %s[bpc%0d] result (a=%h b=%h s=%0d): got %h want %h",
                 name, bpc_of(i), a, b, sg, obs_res[i], e_res);
      end
      checks++;
      if (obs_dz[i] !== e_dz || obs_ov[i] !== e_ov) begin
        errors++;
        $display("FAIL %s[bpc%0d] flags dz/ov: got %0d/%0d want %0d/%0d",
                 name, bpc_of(i), obs_dz[i], obs_ov[i], e_dz, e_ov);
      end
      checks++;
      if (obs_pulses[i] !== 1) begin
        errors++;
        $display("FAIL %s[bpc%0d] ready pulse cycles: got %0d want 1", name, bpc_of(i), obs_pulses[i]);
      end
      checks++;
      if ({obs_end_res[i], obs_end_dz[i], obs_end_ov[i]} !== {e_res, e_dz, e_ov}) begin
        errors++;
        $display("FAIL %s[bpc%0d] hold after ready: got %h/%0d/%0d want %h/%0d/%0d", name,
                 bpc_of(i), obs_end_res[i], obs_end_dz[i], obs_end_ov[i], e_res, e_dz, e_ov);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bsy[i], rdy[i], dz[i], ov[i]} !== 4'b0000 || res[i] !== '0) begin
        errors++;
        $display("FAIL reset[bpc%0d] busy/ready/dz/ov/result: got %0d/%0d/%0d/%0d/%h want all 0",
                 bpc_of(i), bsy[i], rdy[i], dz[i], ov[i], res[i]);
      end
    end
    @(negedge clk);
    resetn = 1'b1;
    test_single_divide(32'd100, 32'd7, 1'b0, "first_edge_after_reset", 1'b1);
  endtask

  task automatic test_directed();
    test_single_divide(32'd100,       32'd7,        1'b0, "u_100_7",      1'b0);
    test_single_divide(32'hFFFF_FFF9, 32'd2,        1'b1, "s_m7_2",       1'b0);
    test_single_divide(32'd7,         32'hFFFF_FFFE, 1'b1, "s_7_m2",      1'b0);
    test_single_divide(32'h1234_5678, 32'd0,        1'b0, "u_div_zero",   1'b0);
    test_single_divide(32'hF234_5678, 32'd0,        1'b1, "s_div_zero",   1'b0);
    test_single_divide(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_overflow",  1'b0);
    test_single_divide(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "u_min_allone", 1'b0);
    test_single_divide(32'hFFFF_FFFF, 32'h10,       1'b0, "u_ffff_16",    1'b0);
    test_single_divide(32'h8000_0000, 32'd3,        1'b1, "s_min_3",      1'b0);
    test_single_divide(32'd5,         32'd9,        1'b0, "u_small_big",  1'b0);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic sg;
    for (int n = 0; n < 30; n++) begin
      a  = $urandom;
      b  = $urandom;
      sg = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = ~32'($urandom_range(1, 15)) + 32'd1;
        4: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      test_single_divide(a, b, sg, "random", 1'b0);
    end
  endtask

  task automatic test_annul();
    logic [2*W-1:0] prev;
    logic d0, d1;
    int early_rdy, late_rdy;
    test_single_divide(32'd100, 32'd7, 1'b0, "pre_annul", 1'b0);
    prev = model(32'd100, 32'd7, 1'b0, d0, d1);
    launch($urandom, ($urandom | 32'd1) & 32'h7FFF_FFFF, 1'($urandom_range(0, 1)), 1'b0);
    early_rdy = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (rdy[i]) early_rdy++;
      if (k == 5) annul = 1'b1;
    end
    @(negedge clk);
    annul = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bsy[i] !== 1'b0) begin
        errors++;
        $display("FAIL annul[bpc%0d] busy after annul: got %0d want 0", bpc_of(i), bsy[i]);
      end
      checks++;
      if (res[i] !== prev) begin
        errors++;
        $display("FAIL annul[bpc%0d] result changed: got %h want %h", bpc_of(i), res[i], prev);
      end
    end
    late_rdy = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (rdy[i]) late_rdy++;
    end
    checks++;
    if (early_rdy + late_rdy !== 0) begin
      errors++;
      $display("FAIL annul ready pulses: got %0d want 0", early_rdy + late_rdy);
    end
    test_single_divide(32'd9, 32'd3, 1'b0, "after_annul", 1'b0);
  endtask

  task automatic test_reset_mid();
    launch($urandom, 32'($urandom_range(1, 1000)), 1'($urandom_range(0, 1)), 1'b0);
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bsy[i], rdy[i], dz[i], ov[i]} !== 4'b0000 || res[i] !== '0) begin
        errors++;
        $display("FAIL reset_mid[bpc%0d] busy/ready/dz/ov/result: got %0d/%0d/%0d/%0d/%h want all 0",
                 bpc_of(i), bsy[i], rdy[i], dz[i], ov[i], res[i]);
      end
    end
    @(negedge clk);
    resetn = 1'b1;
    test_single_divide(32'hFFFF_FF00, 32'd12, 1'b1, "after_reset_mid", 1'b0);
  endtask

  // BPC=1 instance only: start held high across DONE gives the second accept
  // on the IDLE edge right after DONE.
  task automatic test_back_to_back();
    logic [W-1:0] a1, b1, a2, b2;
    logic [2*W-1:0] e1, e2, g1, g2;
    logic d0, d1;
    int lat1, lat2, idle_cnt;
    a1 = $urandom; b1 = 32'($urandom_range(1, 50000));
    a2 = $urandom; b2 = $urandom >> 8;
    if (b2 == 0) b2 = 32'd3;
    e1 = model(a1, b1, 1'b0, d0, d1);
    e2 = model(a2, b2, 1'b1, d0, d1);
    lat1 = -1; lat2 = -1; idle_cnt = 0; g1 = '0; g2 = '0;
    @(negedge clk);
    op1 = a1; op2 = b1; sdiv = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    op1 = a2; op2 = b2; sdiv = 1'b1;
    for (int k = 1; k <= 75; k++) begin
      @(negedge clk);
      if (rdy[0]) begin
        if (lat1 < 0) begin lat1 = k; g1 = res[0]; end
        else if (lat2 < 0) begin lat2 = k; g2 = res[0]; end
      end
      if (k <= 69 && !bsy[0]) idle_cnt++;
      if (k == 36) start = 1'b0;
    end
    checks++;
    if (lat1 !== 34 || g1 !== e1) begin
      errors++;
      $display("FAIL b2b first: got lat %0d res %h want lat 34 res %h", lat1, g1, e1);
    end
    checks++;
    if (lat2 !== 69 || g2 !== e2) begin
      errors++;
      $display("FAIL b2b second: got lat %0d res %h want lat 69 res %h", lat2, g2, e2);
    end
    checks++;
    if (idle_cnt !== 1) begin
      errors++;
      $display("FAIL b2b idle gap cycles: got %0d want 1", idle_cnt);
    end
    repeat (40) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_annul();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_param.md
DIV_PARAM -- requirements
Module: div_param

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, meaning operand width in bits; legal values are even and at least 8.
REQ-002 SHALL provide parameter BPC, default 1, meaning quotient bits retired per iteration; legal values are 1, 2 or 4, and BPC SHALL divide WIDTH.
REQ-003 SHALL provide port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL provide port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL provide port start_i, input, 1 bit: request; sampled only in IDLE.
REQ-006 SHALL provide port annul_i, input, 1 bit: cancels an operation in flight.
REQ-007 SHALL provide port signed_div_i, input, 1 bit: 1 selects two's-complement, 0 selects unsigned.
REQ-008 SHALL provide port opdata1_i, input, WIDTH bits: dividend.
REQ-009 SHALL provide port opdata2_i, input, WIDTH bits: divisor.
REQ-010 SHALL provide port busy_o, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL provide port ready_o, output, 1 bit: one-cycle pulse marking a valid result.
REQ-012 SHALL provide port result_o, output, 2*WIDTH bits: {remainder, quotient}.
REQ-013 SHALL provide port div_zero_o, output, 1 bit: the current result came from a zero divisor.
REQ-014 SHALL provide port overflow_o, output, 1 bit: the current result came from signed MIN / -1.

Function
REQ-015 SHALL implement states IDLE, CALC, FIX and DONE.
REQ-016 SHALL accept a request only on an edge where the state is IDLE, start_i=1 and annul_i=0; operands, signed_div_i and the operand signs are captured on that edge, and later input changes SHALL NOT affect the operation.
REQ-017 SHALL, on accept with divisor 0, go to DONE with quotient all-ones, remainder equal to opdata1_i unmodified, and div_zero_o=1.
REQ-018 SHALL, on accept with signed_div_i=1, opdata1_i=MIN (only MSB set) and opdata2_i=all-ones, go to DONE with quotient MIN, remainder 0 and overflow_o=1.
REQ-019 SHALL otherwise load the magnitudes (two's-complement negate the negative operands when signed), clear the iteration counter and enter CALC.
REQ-020 SHALL, in CALC, perform BPC restoring subtract-shift steps per edge on the partial remainder, for exactly WIDTH/BPC edges, then enter FIX.
REQ-021 SHALL, in FIX, negate the quotient when signed and the operand signs differ, negate the remainder when signed and the dividend is negative, register result_o and enter DONE.
REQ-022 SHALL, in DONE, drive ready_o=1 for exactly one cycle and return to IDLE on the following edge.
REQ-023 SHALL hold result_o, div_zero_o and overflow_o stable after ready_o until the next accepted request, which clears both flags.
REQ-024 SHALL place ready_o high WIDTH/BPC+2 edges after the accepting edge for a normal divide, and 1 edge after it for zero-divisor or overflow.
REQ-025 SHALL, when annul_i=1 in CALC or FIX, return to IDLE on that edge without pulsing ready_o and without changing result_o; annul_i SHALL be ignored in DONE.
REQ-026 SHALL accept a new start_i in the IDLE cycle immediately after DONE, which gives back-to-back operation.
REQ-027 SHALL satisfy dividend = quotient*divisor + remainder for every nonzero divisor, with |remainder| < |divisor| and the remainder carrying the dividend's sign (truncating division).

Reset
REQ-028 SHALL, while resetn=0 at any time and in any state, force state IDLE, busy_o=0, ready_o=0, result_o=0, div_zero_o=0, overflow_o=0 and counter 0, discarding any operation in flight.
REQ-029 SHALL accept a request on the first rising edge after resetn deasserts.

Verification (WIDTH=32 unless stated)
REQ-030 SHALL cover: BPC=1, unsigned 100/7 -> ready_o 34 edges after accept, result_o = {0x00000002, 0x0000000E}.
REQ-031 SHALL cover: BPC=1, signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
REQ-032 SHALL cover: 0x12345678/0 -> ready_o 1 edge after accept, quotient 0xFFFFFFFF, remainder 0x12345678, div_zero_o=1; signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0, overflow_o=1.
REQ-033 SHALL cover: BPC=2, unsigned 0xFFFFFFFF/0x10 -> ready_o 18 edges after accept, quotient 0x0FFFFFFF, remainder 0xF.
REQ-034 SHALL cover: annul_i pulsed 5 cycles into CALC -> no ready_o, busy_o low the next cycle, result_o unchanged; then 9/3 -> quotient 3, remainder 0.
REQ-035 SHALL cover: resetn asserted mid-CALC -> all outputs 0 immediately; a divide after release completes correctly.
